// File: rtl/regfile_wr_arb_pkg.sv
// regfile_wr_arb_pkg
//   Shared constants and types for the two-requester register-file write
//   arbiter: register-number / data widths, register count, the queued
//   write entry {wn, d}, the round-robin pointer encoding and a one-hot
//   register decode helper used to build the pending-write bitmap.
package regfile_wr_arb_pkg;

  localparam int REG_W  = 5;   // register number width
  localparam int DATA_W = 32;  // write data width
  localparam int REG_N  = 32;  // number of architectural registers

  // One queued register-file write.
  typedef struct packed {
    logic [REG_W-1:0]  wn;
    logic [DATA_W-1:0] d;
  } entry_t;

  // Round-robin pointer: names the requester that wins a tie.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_e;

  // One-hot mask with the bit for register n set.
  function automatic logic [REG_N-1:0] reg_bit(input logic [REG_W-1:0] n);
    logic [REG_N-1:0] m;
    m    = '0;
    m[n] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wr_arb_if.sv
// regfile_wr_arb_if
//   Bundles the requester handshakes and the register-file write port.
//   master : requester / register-file side (drives v*, wn*, d*)
//   slave  : the arbiter (drives rdy*, we, wn, d, pend)
//   Signals:
//     v0/v1     requester write-request valid
//     rdy0/rdy1 requester ready
//     wn0/wn1   requester destination register number
//     d0/d1     requester write data
//     we/wn/d   registered write port to the register file
//     pend      bitmap of registers with a write still in flight
interface regfile_wr_arb_if;
  import regfile_wr_arb_pkg::*;

  logic              v0;
  logic              v1;
  logic              rdy0;
  logic              rdy1;
  logic [REG_W-1:0]  wn0;
  logic [REG_W-1:0]  wn1;
  logic [DATA_W-1:0] d0;
  logic [DATA_W-1:0] d1;
  logic              we;
  logic [REG_W-1:0]  wn;
  logic [DATA_W-1:0] d;
  logic [REG_N-1:0]  pend;

  modport master (
    output v0, v1, wn0, wn1, d0, d1,
    input  rdy0, rdy1, we, wn, d, pend
  );

  modport slave (
    input  v0, v1, wn0, wn1, d0, d1,
    output rdy0, rdy1, we, wn, d, pend
  );

endinterface

// File: rtl/regfile_wr_arb_fifo.sv
// regfile_wr_fifo
//   Per-requester write queue of DEPTH entries (DEPTH = 2 or 4).
//   Ports:
//     clk, clrn   clock, synchronous active-low reset (empties the queue)
//     push        enqueue push_data (ignored when full)
//     push_data   entry to enqueue
//     pop         dequeue head (ignored when empty)
//     full/empty  occupancy flags from registered count
//     head        oldest entry
//     entries     raw storage slots, qualified by valid, for the pend bitmap
//     valid       per-slot occupied flags
module regfile_wr_fifo
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output entry_t           head,
  output entry_t           entries [DEPTH],
  output logic [DEPTH-1:0] valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic do_push;
  logic do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    if (do_pop) begin
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      valid_d[rd_ptr_q] = 1'b0;
    end
    // Push never targets the slot being popped: a push needs room and a
    // pop needs an entry, so the two pointers differ whenever both fire.
    if (do_push) begin
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage carries no reset; slot occupancy is tracked by valid_q.
  always_ff @(posedge clk) begin
    if (clrn && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = valid_q;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign entries[gi] = mem_q[gi];
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
//   Two-requester write arbiter in front of a single register-file write
//   port. Each requester has its own FIFO; non-empty heads are arbitrated
//   every cycle (sole non-empty wins, ties broken by a round-robin
//   pointer) and the winner is registered onto we/wn/d. Writes to
//   register 0 are dropped at acceptance. pend flags every register with
//   a queued or currently-issuing write.
//   Ports:
//     clk   clock, rising edge
//     clrn  synchronous active-low reset
//     bus   slave side of regfile_wr_arb_if
module regfile_wr_arb
  import regfile_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  clrn,
  regfile_wr_arb_if.slave       bus
);

  logic [1:0]            v;
  logic [1:0]            rdy;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            full;
  logic [1:0]            empty;
  logic [1:0]            grant;
  entry_t [1:0]          req;
  entry_t [1:0]          head;
  logic [1:0][REG_N-1:0] fifo_pend;

  rr_e               rr_q, rr_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  wn_q, wn_d;
  logic [DATA_W-1:0] d_q, d_d;

  assign v      = {bus.v1, bus.v0};
  assign req[0] = '{wn: bus.wn0, d: bus.d0};
  assign req[1] = '{wn: bus.wn1, d: bus.d1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    entry_t           fifo_ent [DEPTH];
    logic [DEPTH-1:0] fifo_vld;
    logic [REG_N-1:0] mask;

    // Ready reflects registered occupancy only, so a same-cycle pop
    // cannot make room for a same-cycle push.
    assign rdy[gi]  = clrn & ~full[gi];
    // Register 0 writes are accepted but dropped here.
    assign push[gi] = v[gi] & rdy[gi] & (req[gi].wn != '0);
    assign pop[gi]  = grant[gi];

    regfile_wr_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .clrn      (clrn),
      .push      (push[gi]),
      .push_data (req[gi]),
      .pop       (pop[gi]),
      .full      (full[gi]),
      .empty     (empty[gi]),
      .head      (head[gi]),
      .entries   (fifo_ent),
      .valid     (fifo_vld)
    );

    always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_vld[i]) begin
          mask = mask | reg_bit(fifo_ent[i].wn);
        end
      end
    end

    assign fifo_pend[gi] = mask;
  end

  // Arbitration and next output-stage state.
  always_comb begin
    grant = '0;
    rr_d  = rr_q;
    we_d  = 1'b0;
    wn_d  = wn_q;
    d_d   = d_q;
    if (!empty[0] && (empty[1] || rr_q == RR_REQ0)) begin
      grant[0] = 1'b1;
    end else if (!empty[1]) begin
      grant[1] = 1'b1;
    end
    if (grant[0]) begin
      we_d = 1'b1;
      wn_d = head[0].wn;
      d_d  = head[0].d;
      rr_d = RR_REQ1;
    end else if (grant[1]) begin
      we_d = 1'b1;
      wn_d = head[1].wn;
      d_d  = head[1].d;
      rr_d = RR_REQ0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      rr_q <= RR_REQ0;
      we_q <= 1'b0;
      wn_q <= '0;
      d_q  <= '0;
    end else begin
      rr_q <= rr_d;
      we_q <= we_d;
      wn_q <= wn_d;
      d_q  <= d_d;
    end
  end

  assign bus.rdy0 = rdy[0];
  assign bus.rdy1 = rdy[1];
  assign bus.we   = we_q;
  assign bus.wn   = wn_q;
  assign bus.d    = d_q;
  // Queued writes plus the one on the port this cycle; register 0 is
  // never reported since writes to it never reach a FIFO.
  assign bus.pend = (fifo_pend[0] | fifo_pend[1] |
                     (we_q ? reg_bit(wn_q) : '0)) & ~REG_N'(1);

endmodule

// File: tb/tb_regfile_wr_arb.sv
module tb_regfile_wr_arb;
  import regfile_wr_arb_pkg::*;

  logic clk  = 1'b0;
  logic clrn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int          wait0 = 0;
  int          wait1 = 0;
  int          n_acc = 0;
  int          n_wr  = 0;

  regfile_wr_arb_if bus();

  regfile_wr_arb #(.DEPTH(2)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we) $display("write wn=%0d d=%08h", bus.wn, bus.d);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.v0  = 1'b0;
    bus.v1  = 1'b0;
    bus.wn0 = '0;
    bus.wn1 = '0;
    bus.d0  = '0;
    bus.d1  = '0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    step();
    step();
    clrn = 1'b1;
    #1;
  endtask

  // Checks the output stage after an edge against the model queues.
  // ne0/ne1 are the model occupancies before the edge.
  task automatic check_out(input logic ne0, input logic ne1);
    logic [36:0] exp;
    chk("soak_grant", 64'(bus.we), 64'(ne0 || ne1));
    if (bus.we) begin
      n_wr++;
      if (bus.d[31] == 1'b0) begin
        chk("soak_q0_nonempty", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) begin
          exp = q0.pop_front();
          chk("soak_data0", 64'({bus.wn, bus.d}), 64'(exp));
        end
        wait0 = 0;
        if (ne1) wait1++;
      end else begin
        chk("soak_q1_nonempty", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) begin
          exp = q1.pop_front();
          chk("soak_data1", 64'({bus.wn, bus.d}), 64'(exp));
        end
        wait1 = 0;
        if (ne0) wait0++;
      end
      chk("soak_starve", 64'(wait0 <= 1 && wait1 <= 1), 64'd1);
    end
  endtask

  initial begin
    logic ne0;
    logic ne1;

    // ---- reset state
    idle();
    clrn = 1'b0;
    step();
    step();
    chk("rst_we",   64'(bus.we),   64'd0);
    chk("rst_wn",   64'(bus.wn),   64'd0);
    chk("rst_d",    64'(bus.d),    64'd0);
    chk("rst_pend", 64'(bus.pend), 64'd0);
    chk("rst_rdy0", 64'(bus.rdy0), 64'd0);
    chk("rst_rdy1", 64'(bus.rdy1), 64'd0);
    clrn = 1'b1;
    #1;
    chk("rst_rdy0_rel", 64'(bus.rdy0), 64'd1);
    chk("rst_rdy1_rel", 64'(bus.rdy1), 64'd1);

    // ---- single write: wn=5, d=AA
    bus.v0 = 1'b1; bus.wn0 = 5'd5; bus.d0 = 32'h0000_00AA;
    chk("sw_rdy0", 64'(bus.rdy0), 64'd1);
    step();
    idle();
    chk("sw_pend_acc", 64'(bus.pend), 64'h20);
    chk("sw_we_early", 64'(bus.we), 64'd0);
    step();
    chk("sw_out",     64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd5, 32'h0000_00AA});
    chk("sw_pend_we", 64'(bus.pend), 64'h20);
    step();
    chk("sw_we_off",  64'(bus.we),   64'd0);
    chk("sw_pend_off", 64'(bus.pend), 64'd0);
    chk("sw_hold",    64'({bus.wn, bus.d}), {27'd0, 5'd5, 32'h0000_00AA});

    // ---- contention with rr=0
    do_reset();
    bus.v0 = 1'b1; bus.wn0 = 5'd3; bus.d0 = 32'h11;
    bus.v1 = 1'b1; bus.wn1 = 5'd4; bus.d1 = 32'h22;
    step();
    idle();
    chk("ct_pend", 64'(bus.pend), 64'h18);
    chk("ct_we0",  64'(bus.we),   64'd0);
    step();
    chk("ct_first",  64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd3, 32'h11});
    chk("ct_pend1",  64'(bus.pend), 64'h18);
    step();
    chk("ct_second", 64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd4, 32'h22});
    chk("ct_pend2",  64'(bus.pend), 64'h10);
    step();
    chk("ct_idle", 64'(bus.we), 64'd0);
    // rr must be back at 0: a fresh tie goes to requester 0 first
    bus.v0 = 1'b1; bus.wn0 = 5'd6; bus.d0 = 32'h33;
    bus.v1 = 1'b1; bus.wn1 = 5'd7; bus.d1 = 32'h44;
    step();
    idle();
    step();
    chk("ct_rr_first",  64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd6, 32'h33});
    step();
    chk("ct_rr_second", 64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd7, 32'h44});
    step();
    chk("ct_rr_idle", 64'(bus.we), 64'd0);

    // ---- full / backpressure on requester 1
    bus.v0 = 1'b1; bus.wn0 = 5'd8; bus.d0 = 32'h80;
    bus.v1 = 1'b1; bus.wn1 = 5'd9; bus.d1 = 32'h91;
    chk("bp_rdy1_empty", 64'(bus.rdy1), 64'd1);
    step();
    bus.v0 = 1'b0;
    bus.d1 = 32'h92;
    chk("bp_rdy1_one", 64'(bus.rdy1), 64'd1);
    step();
    chk("bp_out0",       64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd8, 32'h80});
    chk("bp_rdy1_full",  64'(bus.rdy1), 64'd0);
    bus.d1 = 32'h93;
    step();
    chk("bp_out1",       64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd9, 32'h91});
    chk("bp_rdy1_rise",  64'(bus.rdy1), 64'd1);
    idle();
    step();
    chk("bp_out2",       64'({bus.we, bus.wn, bus.d}), {26'd0, 1'b1, 5'd9, 32'h92});
    step();
    chk("bp_no_third",   64'(bus.we),   64'd0);
    chk("bp_pend",       64'(bus.pend), 64'd0);

    // ---- register 0 discarded
    bus.v0 = 1'b1; bus.wn0 = 5'd0; bus.d0 = 32'hFFFF_FFFF;
    chk("r0_rdy0", 64'(bus.rdy0), 64'd1);
    step();
    idle();
    chk("r0_pend_a", 64'(bus.pend), 64'd0);
    chk("r0_we_a",   64'(bus.we),   64'd0);
    step();
    chk("r0_pend_b", 64'(bus.pend), 64'd0);
    chk("r0_we_b",   64'(bus.we),   64'd0);
    step();
    chk("r0_we_c",   64'(bus.we),   64'd0);

    // ---- reset mid-operation
    bus.v0 = 1'b1; bus.wn0 = 5'd10; bus.d0 = 32'hA0;
    bus.v1 = 1'b1; bus.wn1 = 5'd11; bus.d1 = 32'hB0;
    step();
    bus.wn0 = 5'd12; bus.d0 = 32'hA1;
    bus.wn1 = 5'd13; bus.d1 = 32'hB1;
    step();
    idle();
    clrn = 1'b0;
    #1;
    chk("mr_rdy0_in", 64'(bus.rdy0), 64'd0);
    chk("mr_rdy1_in", 64'(bus.rdy1), 64'd0);
    step();
    chk("mr_we",   64'(bus.we),   64'd0);
    chk("mr_pend", 64'(bus.pend), 64'd0);
    chk("mr_wnd",  64'({bus.wn, bus.d}), 64'd0);
    chk("mr_rdy",  64'({bus.rdy0, bus.rdy1}), 64'd0);
    clrn = 1'b1;
    #1;
    chk("mr_rdy0_rel", 64'(bus.rdy0), 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mr_stale_we",   64'(bus.we),   64'd0);
      chk("mr_stale_pend", 64'(bus.pend), 64'd0);
    end

    // ---- random soak with scoreboard
    for (int i = 0; i < 300; i++) begin
      bus.v0  = 1'($urandom_range(0, 1));
      bus.wn0 = 5'($urandom_range(0, 31));
      bus.d0  = {1'b0, 31'(i)};
      bus.v1  = 1'($urandom_range(0, 1));
      bus.wn1 = 5'($urandom_range(0, 31));
      bus.d1  = {1'b1, 31'(i)};
      ne0 = (q0.size() != 0);
      ne1 = (q1.size() != 0);
      if (bus.v0 && bus.rdy0 && bus.wn0 != 5'd0) begin
        q0.push_back({bus.wn0, bus.d0});
        n_acc++;
      end
      if (bus.v1 && bus.rdy1 && bus.wn1 != 5'd0) begin
        q1.push_back({bus.wn1, bus.d1});
        n_acc++;
      end
      step();
      check_out(ne0, ne1);
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      ne0 = (q0.size() != 0);
      ne1 = (q1.size() != 0);
      step();
      check_out(ne0, ne1);
    end
    chk("soak_q0_drained", 64'(q0.size()), 64'd0);
    chk("soak_q1_drained", 64'(q1.size()), 64'd0);
    chk("soak_count",      64'(n_wr),      64'(n_acc));
    chk("soak_pend_end",   64'(bus.pend),  64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning per-requester FIFO depth in entries, legal values 2 and 4.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clrn, input, 1, reset; it is synchronous and active-low.
REQ-004 The block SHALL have ports v0 and v1, input, 1 each, requester 0/1 write-request valid.
REQ-005 The block SHALL have ports rdy0 and rdy1, output, 1 each, requester 0/1 ready.
REQ-006 The block SHALL have ports wn0 and wn1, input, 5 each, requester 0/1 destination register number.
REQ-007 The block SHALL have ports d0 and d1, input, 32 each, requester 0/1 write data.
REQ-008 The block SHALL have port we, output, 1, registered write enable to the register file write port.
REQ-009 The block SHALL have port wn, output, 5, registered write register number to the register file.
REQ-010 The block SHALL have port d, output, 32, registered write data to the register file.
REQ-011 The block SHALL have port pend, output, 32, bitmap of registers with a write still in flight.

Function
REQ-012 The block SHALL accept a request from requester k at a rising edge where vk=1 and rdyk=1.
REQ-013 rdyk SHALL be 1 exactly when FIFO k holds fewer than DEPTH entries and clrn=1; a pop in the same cycle SHALL NOT raise rdyk.
REQ-014 An accepted request with wnk=0 SHALL be discarded, never enqueued, and never cause we=1.
REQ-015 An accepted request with wnk!=0 SHALL be pushed as {wnk, dk} into FIFO k; order within each requester SHALL be preserved.
REQ-016 Each cycle the block SHALL arbitrate between non-empty FIFO heads.
REQ-017 A sole non-empty FIFO SHALL win; if both FIFOs are non-empty, the FIFO named by round-robin pointer rr SHALL win.
REQ-018 After any grant, rr SHALL be set to the non-winning requester; with no grant, rr SHALL hold.
REQ-019 On a grant, the winner's head SHALL be popped and, at the same edge, loaded into we=1, wn, and d.
REQ-020 With no grant, we SHALL be 0, and wn and d SHALL hold their previous values.
REQ-021 A request accepted at edge N SHALL give the earliest we=1 in the cycle after edge N+1; there SHALL be no bypass from the inputs to the outputs.
REQ-022 Simultaneous push and pop on one FIFO SHALL leave its count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 pend[i] SHALL be 1 when any valid FIFO entry or the output stage (we=1) targets register i, combinationally from current state; pend[0] SHALL always be 0.
REQ-024 No ordering SHALL be guaranteed between requesters writing the same register; the last granted write wins.

Reset
REQ-025 While clrn=0 at a rising edge, both FIFOs SHALL be emptied, and rr, we, wn, and d SHALL be set to 0.
REQ-026 While clrn=0, rdy0 and rdy1 SHALL be 0 and no request SHALL be accepted.
REQ-027 A reset mid-operation SHALL discard all queued writes, with no partial write emitted afterwards.

Structure
REQ-028 A shared package SHALL hold the register-number width (5), data width (32), and register count (32) constants, plus the {wn, d} entry typedef.
REQ-029 The per-requester queue SHALL be one sub-module, regfile_wr_fifo (parameter DEPTH, push/pop/full/empty, entry contents exposed for pend), instantiated twice.

Verification
REQ-030 Single write: reset; v0=1, wn0=5, d0=0x0000_00AA for one accepting edge -> we=1, wn=5, d=0xAA exactly one cycle, two edges after acceptance; pend[5]=1 from acceptance until that cycle ends.
REQ-031 Contention: both FIFOs hold one entry each (wn0=3/d0=0x11, wn1=4/d1=0x22), rr=0 -> output order 3/0x11 then 4/0x22 on consecutive cycles; rr ends at 0.
REQ-032 Full/backpressure, DEPTH=2: v1 held high with the output not draining requester 1 (requester 0 always granted first) -> rdy1=0 after 2 accepted entries; no third entry accepted until a pop, and rdy1 rises the cycle after that pop.
REQ-033 Register 0: v0=1, wn0=0, d0=0xFFFF_FFFF -> rdy0=1, we never asserted, pend=0.
REQ-034 Reset mid-operation: 2 entries queued per requester, clrn=0 for one edge -> we=0, pend=0, rdy0=rdy1=0 during reset; after clrn=1, no stale write appears.
REQ-035 Random soak: random v0/v1 with constrained wn/d -> a scoreboard shows every non-zero request written exactly once, in per-requester order, with no starvation beyond 1 intervening grant.
